// File: rtl/atom_loader.sv
// atom_loader: assembles 14-byte atom records from a framed byte stream
// and writes each one to the atom register file (ATOM_LOADER_CHECKSUM_EN adds a trailing XOR check).
module atom_loader #(
    parameter int MAX_ATOMS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        clear,
    output logic        we,
    output logic [5:0]  w_addr,
    output logic [31:0] w_x,
    output logic [31:0] w_y,
    output logic [31:0] w_z,
    output logic [4:0]  w_res_id,
    output logic [3:0]  w_atom_idx,
    output logic        busy,
    output logic        done,
    output logic [6:0]  atom_count,
    output logic        err
);

    localparam logic [6:0] MAX_N = 7'(MAX_ATOMS);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CKSUM,
        DONE
    } state_t;

    state_t      state;
    logic [6:0]  n_rec;
    logic [3:0]  byte_cnt;
    logic [95:0] shreg;
    logic [4:0]  res_buf;
    logic        xfer;
    logic        last;
    logic [6:0]  hdr_n;

    assign xfer     = in_valid && in_ready;
    assign in_ready = (state == IDLE) || (state == RECV) || (state == CKSUM);
    assign busy     = (state != IDLE);
    assign last     = (atom_count + 7'd1) >= n_rec;
    assign hdr_n    = (in_data == 8'd0 || in_data > 8'(MAX_ATOMS)) ? MAX_N : in_data[6:0];

`ifdef ATOM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;

    assign err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum  <= 8'd0;
            err_q <= 1'b0;
        end else if (!clear && xfer) begin
            case (state)
                IDLE: begin
                    csum  <= in_data;
                    err_q <= 1'b0;
                end
                RECV:    csum  <= csum ^ in_data;
                CKSUM:   err_q <= (in_data != csum);
                default: ;
            endcase
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            n_rec      <= 7'd0;
            byte_cnt   <= 4'd0;
            shreg      <= 96'd0;
            res_buf    <= 5'd0;
            we         <= 1'b0;
            done       <= 1'b0;
            w_addr     <= 6'd0;
            w_x        <= 32'd0;
            w_y        <= 32'd0;
            w_z        <= 32'd0;
            w_res_id   <= 5'd0;
            w_atom_idx <= 4'd0;
            atom_count <= 7'd0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            if (clear) begin
                // a write already on the port this cycle still counts
                if (state == WRITE)
                    atom_count <= atom_count + 7'd1;
                byte_cnt <= 4'd0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (xfer) begin
                            n_rec      <= hdr_n;
                            w_addr     <= 6'd0;
                            atom_count <= 7'd0;
                            byte_cnt   <= 4'd0;
                            state      <= RECV;
                        end
                    end
                    RECV: begin
                        if (xfer) begin
                            byte_cnt <= byte_cnt + 4'd1;
                            if (byte_cnt < 4'd12) begin
                                shreg <= {in_data, shreg[95:8]};
                            end else if (byte_cnt == 4'd12) begin
                                res_buf <= in_data[4:0];
                            end else begin
                                w_x        <= shreg[31:0];
                                w_y        <= shreg[63:32];
                                w_z        <= shreg[95:64];
                                w_res_id   <= res_buf;
                                w_atom_idx <= in_data[3:0];
                                byte_cnt   <= 4'd0;
                                we         <= 1'b1;
                                state      <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        atom_count <= atom_count + 7'd1;
                        if (last) begin
`ifdef ATOM_LOADER_CHECKSUM_EN
                            state <= CKSUM;
`else
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end else begin
                            w_addr <= w_addr + 6'd1;
                            state  <= RECV;
                        end
                    end
`ifdef ATOM_LOADER_CHECKSUM_EN
                    CKSUM: begin
                        if (xfer) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
`endif
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_atom_loader.sv
// Directed bench for atom_loader: record assembly, framing, clear,
// mid-frame reset and (when enabled) checksum handling.
module tb_atom_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic        we;
    logic [5:0]  w_addr;
    logic [31:0] w_x, w_y, w_z;
    logic [4:0]  w_res_id;
    logic [3:0]  w_atom_idx;
    logic        busy, done, err;
    logic [6:0]  atom_count;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int rdy_bad = 0;
    logic [110:0] q_rec[$];

    atom_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear), .we(we), .w_addr(w_addr),
        .w_x(w_x), .w_y(w_y), .w_z(w_z), .w_res_id(w_res_id),
        .w_atom_idx(w_atom_idx), .busy(busy), .done(done),
        .atom_count(atom_count), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (we === 1'b1)
                q_rec.push_back({w_addr, w_x, w_y, w_z, w_res_id, w_atom_idx});
            if (done === 1'b1)
                done_cnt++;
            if (in_ready !== !(we || done))
                rdy_bad++;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int r, input int k, input int salt);
        return 8'(r * 37 + k * 11 + salt * 5 + 3);
    endfunction

    function automatic logic [110:0] exp_rec(input int r, input int salt);
        logic [7:0] b[14];
        for (int k = 0; k < 14; k++) b[k] = gen(r, k, salt);
        return {6'(r), b[3], b[2], b[1], b[0], b[7], b[6], b[5], b[4],
                b[11], b[10], b[9], b[8], b[12][4:0], b[13][3:0]};
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("done_pulse", done_cnt, d0 + 1);
    endtask

    task automatic run_frame(input logic [7:0] hdr, input int nrec, input int salt,
                             input bit gaps, input bit bad_cs);
        logic [7:0] b;
        logic [7:0] cs;
        int d0;
        q_rec.delete();
        d0 = done_cnt;
        cs = hdr;
        send_byte(hdr, 0);
        for (int r = 0; r < nrec; r++)
            for (int k = 0; k < 14; k++) begin
                b = gen(r, k, salt);
                cs ^= b;
                send_byte(b, gaps ? int'($urandom_range(0, 2)) : 0);
            end
`ifdef ATOM_LOADER_CHECKSUM_EN
        send_byte(bad_cs ? (cs ^ 8'h01) : cs, 0);
        check("cs_done", done, 1);
        check("cs_err", err, bad_cs);
`else
        if (bad_cs) check("no_cs_build", 0, 0);
`endif
        wait_done(d0);
    endtask

    task automatic check_frame(input int nrec, input int salt);
        check("n_writes", q_rec.size(), nrec);
        for (int r = 0; r < nrec && r < q_rec.size(); r++)
            check($sformatf("rec%0d", r), q_rec[r], exp_rec(r, salt));
    endtask

    initial begin
        logic [7:0] f1[15];
        logic [7:0] cs;
        int d0;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'd0;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_flags", {we, done, busy, err}, 4'b0000);
        check("rst_addr_cnt", {w_addr, atom_count}, 13'd0);
        check("rst_data", {w_x, w_y, w_z, w_res_id, w_atom_idx}, 105'd0);

        // single hand-built record with sign and boundary values
        f1 = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hFF, 8'hFF, 8'hFF,
               8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hE3, 8'hF5};
        cs = 8'd0;
        q_rec.delete();
        d0 = done_cnt;
        for (int i = 0; i < 15; i++) begin
            cs ^= f1[i];
            send_byte(f1[i], 0);
            if (i == 1) check("t1_busy", busy, 1);
        end
        check("t1_we", we, 1);
        check("t1_ready_write", in_ready, 0);
        check("t1_rec", {w_addr, w_x, w_y, w_z, w_res_id, w_atom_idx},
              {6'd0, 32'h10, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 5'd3, 4'd5});
`ifdef ATOM_LOADER_CHECKSUM_EN
        send_byte(cs, 0);
`else
        @(posedge clk);
        #1;
`endif
        check("t1_done", done, 1);
        check("t1_we_low", we, 0);
        check("t1_count", atom_count, 1);
        check("t1_hold_x", w_x, 32'h10);
        check("t1_err", err, 0);
        @(posedge clk);
        #1;
        check("t1_idle", {busy, done, in_ready}, 3'b001);
        check("t1_ndone", done_cnt, d0 + 1);

        // three records with random valid gaps
        rdy_bad = 0;
        run_frame(8'h03, 3, 1, 1'b1, 1'b0);
        check_frame(3, 1);
        check("t2_count", atom_count, 3);
        check("t2_ready_pattern", rdy_bad, 0);

        // header 0 means a full 64-record frame
        run_frame(8'h00, 64, 2, 1'b0, 1'b0);
        check_frame(64, 2);
        check("t3_count", atom_count, 64);

        // oversized header clamps to 64
        run_frame(8'h50, 64, 3, 1'b0, 1'b0);
        check_frame(64, 3);
        check("t3b_count", atom_count, 64);

        // clear after byte 7 of record 1
        q_rec.delete();
        d0 = done_cnt;
        send_byte(8'h02, 0);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 14; k++)
                if (r == 0 || k <= 7) send_byte(gen(r, k, 4), 0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("t4_idle", {busy, in_ready}, 2'b01);
        repeat (4) @(posedge clk);
        #1;
        check_frame(1, 4);
        check("t4_count", atom_count, 1);
        check("t4_no_done", done_cnt, d0);

        // byte offered together with clear is dropped
        in_data = 8'h01;
        in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear = 1'b0;
        check("t4_drop", busy, 0);

        // reset in the middle of record 0
        q_rec.delete();
        send_byte(8'h01, 0);
        for (int k = 0; k < 4; k++) send_byte(gen(0, k, 5), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_ready", in_ready, 1);
        check("t5_flags", {we, done, busy, err}, 4'b0000);
        check("t5_addr_cnt", {w_addr, atom_count}, 13'd0);
        check("t5_data", {w_x, w_y, w_z, w_res_id, w_atom_idx}, 105'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_no_we", q_rec.size(), 0);
        run_frame(8'h02, 2, 6, 1'b1, 1'b0);
        check_frame(2, 6);
        check("t5_count", atom_count, 2);

`ifdef ATOM_LOADER_CHECKSUM_EN
        run_frame(8'h01, 1, 7, 1'b0, 1'b0);
        check("t6_err_ok", err, 0);
        run_frame(8'h01, 1, 8, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_err_sticky", err, 1);
        send_byte(8'h01, 0);
        check("t6_err_cleared", err, 0);
        cs = 8'h01;
        for (int k = 0; k < 14; k++) begin
            cs ^= gen(0, k, 9);
            send_byte(gen(0, k, 9), 0);
        end
        send_byte(cs, 0);
        check("t6_err_good", {done, err}, 2'b10);
`else
        check("t6_err_tied", err, 0);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
